// File: rtl/ezp_serialize_if.sv
// EZPack serializer bus: descriptor handshake on the source side and the
// ready/valid byte stream on the link side, grouped as one interface.
// master: packet source / byte sink side; slave: the serializer itself.
interface ezp_serialize_if #(
    parameter int MAX_PD_LEN = 2
);
    logic [7:0]              i_type;
    logic [7:0]              i_len;
    logic [8*MAX_PD_LEN-1:0] i_pd;
    logic                    i_valid;
    logic                    i_ready;
    logic [7:0]              o_data;
    logic                    o_valid;
    logic                    o_ready;
    logic                    o_busy;

    modport master (
        output i_type, i_len, i_pd, i_valid, o_ready,
        input  i_ready, o_data, o_valid, o_busy
    );

    modport slave (
        input  i_type, i_len, i_pd, i_valid, o_ready,
        output i_ready, o_data, o_valid, o_busy
    );
endinterface

// File: rtl/ezp_serialize.sv
// ezp_serialize: EZPack transmit packetizer.
// Frame: START, TYPE, LEN, PD[0..MAX_PD_LEN-1] (MSB byte first), CHK, END.
// CHK is the XOR of TYPE, the transmitted LEN and every payload byte.
// Optional feature macro: EZP_SERIALIZE_AUTO_LEN_EN -- when defined the LEN
// byte is forced to MAX_PD_LEN and i_len is ignored.
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | ready for a descriptor, stream idle
// S_START | presenting START_BYTE
// S_TYPE  | presenting captured type
// S_LEN   | presenting captured length
// S_PD    | presenting payload byte at r_idx
// S_CHK   | presenting running checksum
// S_END   | presenting END_BYTE, then back to idle
module ezp_serialize #(
    parameter logic [7:0] START_BYTE = 8'hAA,
    parameter logic [7:0] END_BYTE   = 8'h55,
    parameter int         MAX_PD_LEN = 2
) (
    input  logic          clk,
    input  logic          rst,
    ezp_serialize_if.slave bus
);

    localparam int            IW       = $clog2(MAX_PD_LEN) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(MAX_PD_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TYPE,
        S_LEN,
        S_PD,
        S_CHK,
        S_END
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [7:0]              r_type;
    logic [7:0]              r_len;
    logic [7:0]              r_chk;
    logic [8*MAX_PD_LEN-1:0] r_pd;
    logic [IW-1:0]           r_idx;

    logic [7:0]              w_len_sel;
    logic [8*MAX_PD_LEN-1:0] w_pd_shift;
    logic [7:0]              w_pd_byte;
    logic [7:0]              w_data;
    logic                    w_valid;
    logic                    w_ready;
    logic                    w_fire;

`ifdef EZP_SERIALIZE_AUTO_LEN_EN
    assign w_len_sel = 8'(MAX_PD_LEN);
`else
    assign w_len_sel = bus.i_len;
`endif

    // Shifting the current byte to the top avoids a variable part-select.
    assign w_pd_shift = r_pd << {r_idx, 3'b000};
    assign w_pd_byte  = w_pd_shift[8*MAX_PD_LEN-1 -: 8];
    assign w_fire     = w_valid && bus.o_ready;

    // Next state and state-decoded outputs; o_data/o_valid never see inputs.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_valid      = 1'b0;
        w_data       = 8'h00;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.i_valid) w_next_state = S_START;
            end
            S_START: begin
                w_valid = 1'b1;
                w_data  = START_BYTE;
                if (bus.o_ready) w_next_state = S_TYPE;
            end
            S_TYPE: begin
                w_valid = 1'b1;
                w_data  = r_type;
                if (bus.o_ready) w_next_state = S_LEN;
            end
            S_LEN: begin
                w_valid = 1'b1;
                w_data  = r_len;
                if (bus.o_ready) w_next_state = S_PD;
            end
            S_PD: begin
                w_valid = 1'b1;
                w_data  = w_pd_byte;
                if (bus.o_ready && (r_idx == LAST_IDX)) w_next_state = S_CHK;
            end
            S_CHK: begin
                w_valid = 1'b1;
                w_data  = r_chk;
                if (bus.o_ready) w_next_state = S_END;
            end
            S_END: begin
                w_valid = 1'b1;
                w_data  = END_BYTE;
                if (bus.o_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register, descriptor capture and checksum/index accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_type  <= 8'h00;
            r_len   <= 8'h00;
            r_pd    <= '0;
            r_chk   <= 8'h00;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && bus.i_valid) begin
                r_type <= bus.i_type;
                r_len  <= w_len_sel;
                r_pd   <= bus.i_pd;
                r_chk  <= bus.i_type ^ w_len_sel;
                r_idx  <= '0;
            end
            if ((r_state == S_PD) && w_fire) begin
                r_chk <= r_chk ^ w_pd_byte;
                r_idx <= r_idx + IW'(1);
            end
        end
    end

    assign bus.i_ready = w_ready;
    assign bus.o_valid = w_valid;
    assign bus.o_data  = w_data;
    assign bus.o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_ezp_serialize.sv
// Testbench for ezp_serialize: frame-level queue model checked every cycle,
// plus literal expectations for the directed scenarios and a frame parser
// over a random-backpressure run.
module tb_ezp_serialize;

    localparam int MAXPD = 2;

    logic clk;
    logic rst;
    logic armed;
    logic rand_ready;
    logic fixed_ready;

    int n_cmp;
    int n_bad;
    int cyc;

    logic [7:0] exp_q[$];
    logic [7:0] log_b[$];
    int         log_c[$];
    logic [7:0] lit[$];
    logic [7:0] rec_t[$];
    logic [7:0] rec_l[$];
    logic [8*MAXPD-1:0] rec_pd[$];

    ezp_serialize_if #(.MAX_PD_LEN(MAXPD)) bus ();

    ezp_serialize #(
        .START_BYTE(8'hAA),
        .END_BYTE  (8'h55),
        .MAX_PD_LEN(MAXPD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] len_of(input logic [7:0] l);
`ifdef EZP_SERIALIZE_AUTO_LEN_EN
        return 8'(MAXPD);
`else
        return l;
`endif
    endfunction

    function automatic void push_frame(input logic [7:0] t, input logic [7:0] l,
                                       input logic [8*MAXPD-1:0] pd);
        logic [7:0] c;
        logic [7:0] b;
        c = t ^ len_of(l);
        exp_q.push_back(8'hAA);
        exp_q.push_back(t);
        exp_q.push_back(len_of(l));
        for (int k = 0; k < MAXPD; k++) begin
            b = pd[8*(MAXPD-1-k) +: 8];
            c = c ^ b;
            exp_q.push_back(b);
        end
        exp_q.push_back(c);
        exp_q.push_back(8'h55);
    endfunction

    // Sink-side ready: fixed or random, applied mid-cycle.
    initial begin
        bus.o_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.o_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
        end
    end

    // Per-cycle compare against the frame-queue model.
    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (armed) begin
                check("i_ready", bus.i_ready, exp_q.size() == 0);
                check("o_valid", bus.o_valid, exp_q.size() != 0);
                check("o_busy",  bus.o_busy,  exp_q.size() != 0);
                check("o_data",  bus.o_data,  (exp_q.size() != 0) ? exp_q[0] : 8'h00);
                if (rst) begin
                    exp_q.delete();
                end else if (exp_q.size() != 0) begin
                    if (bus.o_ready) begin
                        log_b.push_back(bus.o_data);
                        log_c.push_back(cyc);
                        void'(exp_q.pop_front());
                    end
                end else if (bus.i_valid) begin
                    push_frame(bus.i_type, bus.i_len, bus.i_pd);
                end
            end
        end
    end

    task automatic send_desc(input logic [7:0] t, input logic [7:0] l,
                             input logic [8*MAXPD-1:0] pd, input bit keep);
        bit ok;
        ok = 1'b0;
        bus.i_type  = t;
        bus.i_len   = l;
        bus.i_pd    = pd;
        bus.i_valid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (bus.i_ready && !rst) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!keep) bus.i_valid = 1'b0;
        check("accept_timeout", ok, 1);
        if (ok) begin
            rec_t.push_back(t);
            rec_l.push_back(l);
            rec_pd.push_back(pd);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 500 && !ok; n++) begin
            @(negedge clk);
            if (bus.i_ready && !bus.o_busy) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        check("idle_timeout", ok, 1);
    endtask

    task automatic clear_log();
        log_b.delete();
        log_c.delete();
        rec_t.delete();
        rec_l.delete();
        rec_pd.delete();
    endtask

    task automatic expect_log(input string name);
        check({name, "_count"}, log_b.size(), lit.size());
        for (int k = 0; k < lit.size() && k < log_b.size(); k++)
            check({name, "_byte"}, log_b[k], lit[k]);
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        armed       = 1'b0;
        rand_ready  = 1'b0;
        fixed_ready = 1'b1;
        rst         = 1'b1;
        bus.i_type  = 8'h00;
        bus.i_len   = 8'h00;
        bus.i_pd    = '0;
        bus.i_valid = 1'b1;   // must be ignored while in reset
        repeat (3) @(posedge clk);
        #1;
        armed       = 1'b1;
        check("rst_i_ready", bus.i_ready, 1);
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_o_busy",  bus.o_busy,  0);
        check("rst_o_data",  bus.o_data,  8'h00);
        bus.i_valid = 1'b0;
        rst         = 1'b0;
        @(posedge clk);
        #1;

        // Basic frame
        clear_log();
        send_desc(8'h01, 8'h02, 16'h1234, 0);
        wait_idle();
        lit = '{8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h25, 8'h55};
        expect_log("basic");
        if (log_c.size() == 7) check("basic_span", log_c[6] - log_c[0], 6);

        // Backpressure on the first payload byte
        clear_log();
        send_desc(8'h01, 8'h02, 16'h1234, 0);
        repeat (3) begin @(posedge clk); #1; end
        fixed_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        fixed_ready = 1'b1;
        wait_idle();
        expect_log("bp");
        if (log_c.size() == 7) check("bp_stall", log_c[3] - log_c[2], 4);

        // Back-to-back with i_valid held high
        clear_log();
        send_desc(8'h01, 8'h02, 16'h1234, 1);
        send_desc(8'h7F, 8'h02, 16'h00FF, 0);
        wait_idle();
        lit = '{8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h25, 8'h55,
                8'hAA, 8'h7F, 8'h02, 8'h00, 8'hFF, 8'h82, 8'h55};
        expect_log("b2b");
        if (log_c.size() == 14) check("b2b_gap", log_c[7] - log_c[6], 2);

        // LEN handling
        clear_log();
        send_desc(8'h01, 8'h07, 16'h1234, 0);
        wait_idle();
`ifdef EZP_SERIALIZE_AUTO_LEN_EN
        lit = '{8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h25, 8'h55};
`else
        lit = '{8'hAA, 8'h01, 8'h07, 8'h12, 8'h34, 8'h20, 8'h55};
`endif
        expect_log("len");

        // Reset while the second payload byte is presented
        clear_log();
        send_desc(8'h01, 8'h02, 16'h1234, 0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_o_valid", bus.o_valid, 0);
        check("midrst_i_ready", bus.i_ready, 1);
        lit = '{8'hAA, 8'h01, 8'h02, 8'h12};
        expect_log("midrst_partial");
        clear_log();
        send_desc(8'h01, 8'h02, 16'h1234, 0);
        wait_idle();
        lit = '{8'hAA, 8'h01, 8'h02, 8'h12, 8'h34, 8'h25, 8'h55};
        expect_log("midrst_after");

        // Random loopback with random sink backpressure, then parse
        clear_log();
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send_desc(8'($urandom), 8'($urandom), 16'($urandom), 0);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
        wait_idle();
        rand_ready = 1'b0;
        begin
            int p;
            logic [7:0] c;
            p = 0;
            check("rnd_count", log_b.size(), rec_t.size() * (MAXPD + 5));
            for (int i = 0; i < rec_t.size(); i++) begin
                if (p + MAXPD + 5 > log_b.size()) break;
                check("rnd_start", log_b[p], 8'hAA);
                check("rnd_type",  log_b[p+1], rec_t[i]);
                check("rnd_len",   log_b[p+2], len_of(rec_l[i]));
                c = log_b[p+1] ^ log_b[p+2];
                for (int k = 0; k < MAXPD; k++) begin
                    check("rnd_pd", log_b[p+3+k], rec_pd[i][8*(MAXPD-1-k) +: 8]);
                    c = c ^ log_b[p+3+k];
                end
                check("rnd_chk", log_b[p+3+MAXPD], c);
                check("rnd_end", log_b[p+4+MAXPD], 8'h55);
                p = p + MAXPD + 5;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
